// File: rtl/ecp5pll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecp5pll_pkg
// Description : Shared types and constants for the ECP5 PLL phase controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ecp5pll_pkg;

  localparam int POS_W  = 10;
  localparam int STEP_W = 10;

  localparam logic DIR_DELAY   = 1'b0;
  localparam logic DIR_ADVANCE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE    = 3'd2,
    ST_GAP      = 3'd3,
    ST_LOCKWAIT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // One fine-phase step with wrap-around inside [0, pos_max]
  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                input logic             dir,
                                                input logic [POS_W-1:0] pos_max);
    if (dir == DIR_ADVANCE) begin
      return (pos == '0) ? pos_max : pos - POS_W'(1);
    end
    return (pos == pos_max) ? '0 : pos + POS_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecp5pll_sync2.sv
`default_nettype none
// ============================================================================
// Module      : ecp5pll_sync2
// Description : Generic two-flop synchroniser, asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ecp5pll_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/ecp5pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ecp5pll_phase_ctrl
// Description : Sequences PLL dynamic phase-shift pulses, re-qualifies lock
//               after each shift and tracks the fine phase of four outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ecp5pll_phase_ctrl
  import ecp5pll_pkg::*;
#(
  parameter int OUT0_DIV     = 1,
  parameter int OUT1_DIV     = 1,
  parameter int OUT2_DIV     = 1,
  parameter int OUT3_DIV     = 1,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_sel_i,
  input  logic               req_dir_i,
  input  logic [STEP_W-1:0]  req_steps_i,
  output logic               done_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               locked_o,
  output logic [4*POS_W-1:0] pos_o,
  input  logic               pll_locked_i,
  output logic [1:0]         pll_phasesel_o,
  output logic               pll_phasedir_o,
  output logic               pll_phasestep_o,
  output logic               pll_phaseloadreg_o
);

  // One shared cycle counter serves SETUP, PULSE, GAP and the LOCKWAIT timeout
  localparam int c_max_a   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int c_max_b   = (GAP_CYCLES > LOCK_TIMEOUT) ? GAP_CYCLES : LOCK_TIMEOUT;
  localparam int c_cnt_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_stb_w   = $clog2(LOCK_STABLE + 1);

  localparam logic [c_cnt_w-1:0] c_setup_last   = c_cnt_w'(SETUP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_pulse_last   = c_cnt_w'(PULSE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_stb_w-1:0] c_stable_last  = c_stb_w'(LOCK_STABLE - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_stb_w-1:0]  r_stable;
  logic [STEP_W-1:0]   r_steps_left;
  logic [1:0]          r_sel;
  logic                r_dir;
  logic                r_err;

  logic w_locked;
  logic w_accept;
  logic w_stepping;
  logic w_lock_lost;
  logic w_step_done;
  logic w_stable_ok;
  logic w_timeout;

  ecp5pll_sync2 #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pll_locked_i),
    .q_o    (w_locked)
  );

  assign w_accept    = req_valid_i && (r_state == ST_IDLE) && w_locked;
  assign w_stepping  = (r_state == ST_SETUP) || (r_state == ST_PULSE) || (r_state == ST_GAP);
  assign w_lock_lost = w_stepping && !w_locked;
  // A step counts only if lock held through its final PULSE cycle
  assign w_step_done = (r_state == ST_PULSE) && (r_cnt == c_pulse_last) && w_locked;
  assign w_stable_ok = (r_state == ST_LOCKWAIT) && w_locked && (r_stable == c_stable_last);
  assign w_timeout   = (r_state == ST_LOCKWAIT) && !w_stable_ok && (r_cnt == c_timeout_last);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection; lock loss while stepping overrides normal progress
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (req_steps_i == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!w_locked)                   w_state_nxt = ST_LOCKWAIT;
        else if (r_cnt == c_setup_last)  w_state_nxt = ST_PULSE;
      end
      ST_PULSE: begin
        if (!w_locked)                   w_state_nxt = ST_LOCKWAIT;
        else if (r_cnt == c_pulse_last)  w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (!w_locked) begin
          w_state_nxt = ST_LOCKWAIT;
        end else if (r_cnt == c_gap_last) begin
          w_state_nxt = (r_steps_left != '0) ? ST_PULSE : ST_LOCKWAIT;
        end
      end
      ST_LOCKWAIT: begin
        if (w_stable_ok || w_timeout) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State outputs; phasestep follows the state register so reset kills it at once
  always_comb begin
    req_ready_o     = (r_state == ST_IDLE) && w_locked;
    busy_o          = (r_state != ST_IDLE);
    done_o          = (r_state == ST_DONE);
    pll_phasestep_o = (r_state == ST_PULSE);
  end

  // Dwell counter restarts on every state change and idles at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_stepping || (r_state == ST_LOCKWAIT)) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Consecutive-lock counter, only meaningful in LOCKWAIT
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stable <= '0;
    end else if ((r_state == ST_LOCKWAIT) && w_locked) begin
      r_stable <= r_stable + c_stb_w'(1);
    end else begin
      r_stable <= '0;
    end
  end

  // Request capture, remaining-step bookkeeping and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel        <= '0;
      r_dir        <= 1'b0;
      r_steps_left <= '0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_sel        <= req_sel_i;
      r_dir        <= req_dir_i;
      r_steps_left <= req_steps_i;
      r_err        <= 1'b0;
    end else begin
      if (w_step_done)             r_steps_left <= r_steps_left - STEP_W'(1);
      if (w_lock_lost || w_timeout) r_err       <= 1'b1;
    end
  end

  // Per-output phase position, wrapping at 8 * divider
  for (genvar gi = 0; gi < 4; gi++) begin : g_pos
    localparam int c_div = (gi == 0) ? OUT0_DIV :
                           (gi == 1) ? OUT1_DIV :
                           (gi == 2) ? OUT2_DIV : OUT3_DIV;
    localparam logic [POS_W-1:0] c_pos_max = POS_W'(8 * c_div - 1);

    logic [POS_W-1:0] r_pos;

    // Advance this output's position when a step on it completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pos <= '0;
      end else if (w_step_done && (r_sel == 2'(gi))) begin
        r_pos <= pos_step(r_pos, r_dir, c_pos_max);
      end
    end

    assign pos_o[POS_W*gi +: POS_W] = r_pos;
  end

  assign err_o              = r_err;
  assign locked_o           = w_locked;
  assign pll_phasesel_o     = r_sel;
  assign pll_phasedir_o     = r_dir;
  assign pll_phaseloadreg_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ecp5pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecp5pll_phase_ctrl
// Description : Self-checking bench: timing-formula reference model compared
//               every cycle, plus directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecp5pll_phase_ctrl;

  localparam int S   = 2;
  localparam int P   = 4;
  localparam int G   = 4;
  localparam int L   = 16;
  localparam int TO  = 100;
  localparam int INF = 32'h3fffffff;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic [1:0] req_sel_i = 2'd0;
  logic       req_dir_i = 1'b0;
  logic [9:0] req_steps_i = 10'd0;
  logic       pll_locked_i = 1'b0;

  logic        req_ready_o, done_o, err_o, busy_o, locked_o;
  logic [39:0] pos_o;
  logic [1:0]  pll_phasesel_o;
  logic        pll_phasedir_o, pll_phasestep_o, pll_phaseloadreg_o;

  always #5 clk = ~clk;

  ecp5pll_phase_ctrl #(
    .OUT0_DIV(1), .OUT1_DIV(1), .OUT2_DIV(2), .OUT3_DIV(1),
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .GAP_CYCLES(G),
    .LOCK_STABLE(L), .LOCK_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_sel_i(req_sel_i), .req_dir_i(req_dir_i), .req_steps_i(req_steps_i),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o), .locked_o(locked_o),
    .pos_o(pos_o), .pll_locked_i(pll_locked_i),
    .pll_phasesel_o(pll_phasesel_o), .pll_phasedir_o(pll_phasedir_o),
    .pll_phasestep_o(pll_phasestep_o), .pll_phaseloadreg_o(pll_phaseloadreg_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  bit m_lk0, m_lk1, m_busy, m_err, m_dir;
  int m_sel, m_T, m_N, m_lw_start, m_done_at, m_run;
  int m_pos [4];

  function automatic int div_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_lk0 = 0; m_lk1 = 0; m_busy = 0; m_err = 0; m_dir = 0;
    m_sel = 0; m_T = 0; m_N = 0; m_lw_start = INF; m_done_at = INF; m_run = 0;
    for (int i = 0; i < 4; i++) m_pos[i] = 0;
  endtask

  // Consume cycle 'cyc' (inputs and expected lock as seen during it)
  task automatic model_step();
    int n, d, w;
    bit lk;
    n  = cyc;
    lk = m_lk1;
    if (!rst_ni) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        if (req_valid_i && lk) begin
          m_busy = 1; m_T = n; m_sel = int'(req_sel_i); m_dir = req_dir_i;
          m_N = int'(req_steps_i); m_err = 0; m_run = 0;
          if (m_N == 0) begin
            m_done_at = n + 1; m_lw_start = INF;
          end else begin
            m_done_at = INF; m_lw_start = n + S + m_N * (P + G) + 1;
          end
        end
      end else if (n == m_done_at) begin
        m_busy = 0;
      end else if (n < m_lw_start) begin
        d = n - m_T;
        w = 8 * div_of(m_sel);
        if (!lk) begin
          m_err = 1; m_lw_start = n + 1;
        end else if (d > S && ((d - S - 1) % (P + G)) == P - 1) begin
          m_pos[m_sel] = m_dir ? (m_pos[m_sel] + w - 1) % w : (m_pos[m_sel] + 1) % w;
        end
      end else begin
        m_run = lk ? m_run + 1 : 0;
        if (m_run == L) m_done_at = n + 1;
        else if (n - m_lw_start + 1 == TO) begin
          m_err = 1; m_done_at = n + 1;
        end
      end
      m_lk1 = m_lk0;
      m_lk0 = pll_locked_i;
    end
  endtask

  function automatic logic [49:0] model_out();
    int  d;
    bit  st;
    d  = cyc - m_T;
    st = m_busy && (cyc < m_lw_start) && (d > S) && (((d - S - 1) % (P + G)) < P);
    return {!m_busy && m_lk1, m_busy && (cyc == m_done_at), m_err, m_busy, m_lk1,
            10'(m_pos[3]), 10'(m_pos[2]), 10'(m_pos[1]), 10'(m_pos[0]),
            2'(m_sel), m_dir, st, 1'b0};
  endfunction

  function automatic logic [49:0] dut_out();
    return {req_ready_o, done_o, err_o, busy_o, locked_o, pos_o,
            pll_phasesel_o, pll_phasedir_o, pll_phasestep_o, pll_phaseloadreg_o};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
    end
  end

  initial forever begin
    @(negedge rst_ni);
    model_reset();
  end

  // Per-cycle comparison against the model
  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      check("cycle_outputs", 64'(dut_out()), 64'(model_out()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int sel, input int dir, input int n, output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_checks++;
      $display("FAIL ready_wait: got ready=0 for 300 cycles, expected ready=1");
    end
    req_sel_i = 2'(sel); req_dir_i = 1'(dir); req_steps_i = 10'(n);
    req_valid_i = 1'b1;
    t = cyc;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic watch(input int limit, output int first_st, output int hi,
                       output int rises, output int done_at);
    logic prev;
    prev = 1'b0; first_st = -1; hi = 0; rises = 0; done_at = -1;
    for (int i = 0; i < limit && done_at < 0; i++) begin
      if (pll_phasestep_o) begin
        hi++;
        if (!prev) begin
          rises++;
          if (first_st < 0) first_st = cyc;
        end
      end
      prev = pll_phasestep_o;
      if (done_o) done_at = cyc;
      @(negedge clk);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t, fs, hi, rs, dn;
    pll_locked_i = 1'b1;
    rst_ni       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(dut_out()), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("ready_before_sync", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    check("ready_after_sync", 64'(req_ready_o), 64'd1);

    // Three delay steps on output 1 with default timing
    send(1, 0, 3, t);
    watch(100, fs, hi, rs, dn);
    check("n3_first_rise", 64'(fs), 64'(t + 3));
    check("n3_pulse_count", 64'(rs), 64'd3);
    check("n3_high_cycles", 64'(hi), 64'd12);
    check("n3_done_cycle", 64'(dn), 64'(t + 43));
    check("n3_pos1", 64'(pos_o[19:10]), 64'd3);

    // Output 2 has divider 2: wraps at 16
    send(2, 1, 1, t);
    watch(100, fs, hi, rs, dn);
    check("div2_advance_wrap", 64'(pos_o[29:20]), 64'd15);
    send(2, 0, 1, t);
    watch(100, fs, hi, rs, dn);
    check("div2_delay_wrap", 64'(pos_o[29:20]), 64'd0);

    // Zero-step request
    send(0, 0, 0, t);
    watch(20, fs, hi, rs, dn);
    check("n0_done_cycle", 64'(dn), 64'(t + 1));
    check("n0_no_pulses", 64'(rs), 64'd0);
    check("n0_pos_kept", 64'(pos_o), 64'h0000000C00);

    // Lock loss during the second pulse of a five-step request
    send(0, 0, 5, t);
    while (cyc < t + 11) @(negedge clk);
    pll_locked_i = 1'b0;
    while (cyc < t + 14) @(negedge clk);
    check("lockloss_step_dropped", 64'(pll_phasestep_o), 64'd0);
    check("lockloss_err", 64'(err_o), 64'd1);
    while (cyc < t + 20) @(negedge clk);
    pll_locked_i = 1'b1;
    watch(100, fs, hi, rs, dn);
    check("lockloss_done_cycle", 64'(dn), 64'(t + 38));
    check("lockloss_pos0", 64'(pos_o[9:0]), 64'd1);

    // Lock held low after the pulses: LOCKWAIT times out
    send(3, 1, 2, t);
    check("err_cleared_on_accept", 64'(err_o), 64'd0);
    while (cyc < t + 18) @(negedge clk);
    pll_locked_i = 1'b0;
    watch(200, fs, hi, rs, dn);
    check("timeout_done_cycle", 64'(dn), 64'(t + 119));
    check("timeout_err", 64'(err_o), 64'd1);
    check("timeout_pos3", 64'(pos_o[39:30]), 64'd6);
    pll_locked_i = 1'b1;
    send(1, 1, 0, t);
    check("err_cleared_after_timeout", 64'(err_o), 64'd0);
    watch(20, fs, hi, rs, dn);

    // Requests while busy are not accepted
    send(0, 0, 1, t);
    while (cyc < t + 5) @(negedge clk);
    req_sel_i = 2'd3; req_steps_i = 10'd7; req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ready_low_busy", 64'(req_ready_o), 64'd0);
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    watch(100, fs, hi, rs, dn);
    check("busy_req_done_cycle", 64'(dn), 64'(t + 27));
    repeat (2) @(negedge clk);
    check("busy_req_not_taken", 64'(busy_o), 64'd0);

    // Requests while unlocked are not accepted
    pll_locked_i = 1'b0;
    repeat (4) @(negedge clk);
    req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ready_low_unlocked", 64'(req_ready_o), 64'd0);
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    check("unlocked_not_taken", 64'(busy_o), 64'd0);
    pll_locked_i = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a pulse
    send(1, 0, 2, t);
    while (cyc < t + 4) @(negedge clk);
    check("pulse_before_reset", 64'(pll_phasestep_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1 check("reset_async_outputs", 64'(dut_out()), 64'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecp5pll_phase_ctrl.md
# ecp5pll_phase_ctrl

Downstream control stage for the parametric ECP5 PLL wrapper. It turns single-beat phase-shift requests ("move output n by N fine steps, delay or advance") into correctly timed pulses on the PLL's dynamic phase port (phasesel / phasedir / phasestep / phaseloadreg). It synchronises the PLL `locked` output and re-qualifies lock after every shift. It also tracks the current fine-phase position of each of the four outputs, for use by DDR read/write levelling logic.

## Interface
- `OUT0_DIV`, default 1: output divider of clk_o[0]; its position wraps at 8*OUT0_DIV.
- `OUT1_DIV`, `OUT2_DIV`, `OUT3_DIV`, default 1: same for clk_o[1..3].
- `SETUP_CYCLES`, default 2: cycles sel/dir are held stable before the first pulse (≥1).
- `PULSE_CYCLES`, default 4: phasestep high time per step (≥1).
- `GAP_CYCLES`, default 4: phasestep low time after each pulse (≥1).
- `LOCK_STABLE`, default 16: consecutive synced-lock cycles required to finish (≥1).
- `LOCK_TIMEOUT`, default 65535: max LOCKWAIT cycles before error.

Ports:
- `clk_i` in 1: control clock, asynchronous to the PLL outputs.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when valid&ready.
- `req_sel_i` in 2: output index 0..3 (maps to clk_o[n]).
- `req_dir_i` in 1: 0 = delay (position +1), 1 = advance (position −1).
- `req_steps_i` in 10: step count N, 0..1023.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky error; cleared on next accepted request.
- `busy_o` out 1: high when not IDLE.
- `locked_o` out 1: synchronised PLL lock.
- `pos_o` out 40: four 10-bit positions; output n occupies bits [10n+9:10n].
- `pll_locked_i` in 1: raw PLL lock (asynchronous).
- `pll_phasesel_o` out 2: to PLL `phasesel`.
- `pll_phasedir_o` out 1: to PLL `phasedir`.
- `pll_phasestep_o` out 1: to PLL `phasestep`.
- `pll_phaseloadreg_o` out 1: tied 0.

## Operation
- `pll_locked_i` passes through a 2-FF synchroniser; the result is `locked_o`. All lock decisions use `locked_o`.
- `req_ready_o` = IDLE && `locked_o`.
- States and transitions:
  - IDLE → SETUP on accept with N>0.
  - IDLE → DONE on accept with N=0. No pulses, no LOCKWAIT, position unchanged.
  - SETUP: S cycles, then → PULSE.
  - PULSE: P cycles, `pll_phasestep_o`=1, then → GAP.
  - GAP: G cycles. If steps remain → PULSE; else → LOCKWAIT.
  - LOCKWAIT: exits to DONE after L consecutive `locked_o`=1 cycles. The consecutive counter resets on any low cycle.
  - DONE: one cycle, `done_o`=1, then → IDLE.
- Request fields are registered at accept. `pll_phasesel_o`/`pll_phasedir_o` are updated on the cycle after accept and held until the next accept.
- Position update: on the last PULSE cycle of each step, pos[sel] += 1 (dir 0) or −1 (dir 1), modulo 8*OUTn_DIV. +1 from 8*DIV−1 → 0; −1 from 0 → 8*DIV−1.
- Lock loss (`locked_o`=0) in SETUP, PULSE or GAP:
  - set `err_o`;
  - drop phasestep the next cycle;
  - abandon the remaining steps and go to LOCKWAIT.
  - A step whose PULSE was interrupted does not update position.
- LOCKWAIT longer than LOCK_TIMEOUT cycles: set `err_o`, go to DONE (`done_o` still pulses).
- `err_o` clears on the accept cycle of a new request.

## Timing
- Reset values:
  - all outputs 0;
  - all positions 0;
  - state IDLE;
  - synchroniser flops 0, so `req_ready_o`=0 until lock has propagated (2 cycles after `pll_locked_i` rises).
- Reset mid-operation: phasestep drops immediately (asynchronous), and all state is lost.
- For an accept at cycle T with N>0 and stable lock:
  - phasestep high during [T+S+1+k(P+G), T+S+k(P+G)+P] for k = 0..N−1;
  - `done_o` at T+S+N(P+G)+L+1.
- For an accept at cycle T with N=0: `done_o` at T+1.
- Defaults with N=3: `done_o` at T+43.
- Counters are wide enough for 1023 steps and LOCK_TIMEOUT; no overflow is permitted.

## Structure
- Package `ecp5pll_pkg`:
  - state enum;
  - direction constants DIR_DELAY=0, DIR_ADVANCE=1;
  - POS_W=10, STEP_W=10.
- Sub-module `ecp5pll_sync2`: generic 2-FF synchroniser with async active-low reset; used for `locked`.

## Test plan
- Reset with lock held high, then request sel=1, dir=0, N=3 at T → 3 pulses each 4 cycles high / 4 low, first rising edge at T+3; `done_o` at T+43; pos[1]=3.
- OUT2_DIV=2; request sel=2, dir=1, N=1 from position 0 → pos[2]=15. Then dir=0, N=1 → pos[2]=0.
- Request with N=0 → `done_o` at T+1; no phasestep activity; positions unchanged.
- Drop `pll_locked_i` during the 2nd PULSE of an N=5 request → phasestep low within 3 cycles; `err_o`=1; pos advanced by 1 only. Restore lock → `done_o` after 16 stable cycles.
- Hold lock low after the pulses with LOCK_TIMEOUT=100 → `err_o`=1 and `done_o` at the timeout. A new request then clears `err_o` on its accept cycle.
- `req_valid_i` asserted while busy or unlocked → `req_ready_o`=0 and nothing is accepted. Assert `rst_ni` low mid-PULSE → all outputs 0 immediately.
